ace_snoop_responder: RTL and testbench

ACE_SNOOP_RESPONDER -- requirements
Module: ace_snoop_responder

---
 rtl/ace_pkg.sv | 120 ++++++++++++
 rtl/ace_snoop_responder.sv | 144 ++++++++++++++
 tb/tb_ace_snoop_responder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ace_pkg.sv
// Shared ACE snoop types: channel structs, ACSNOOP encodings, CRRESP fields and
// the hit/miss response table used by the snoop responder.
package ace_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 64;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;

  typedef logic [3:0] acsnoop_t;

  localparam acsnoop_t ACS_READ_ONCE       = 4'b0000;
  localparam acsnoop_t ACS_READ_SHARED     = 4'b0001;
  localparam acsnoop_t ACS_READ_CLEAN      = 4'b0010;
  localparam acsnoop_t ACS_READ_NSD        = 4'b0011;
  localparam acsnoop_t ACS_READ_UNIQUE     = 4'b0111;
  localparam acsnoop_t ACS_CLEAN_SHARED    = 4'b1000;
  localparam acsnoop_t ACS_CLEAN_INVALID   = 4'b1001;
  localparam acsnoop_t ACS_MAKE_INVALID    = 4'b1101;

  // Bit 0 is DataTransfer, bit 4 is WasUnique.
  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } crresp_t;

  typedef struct packed {
    addr_t    addr;
    acsnoop_t snoop;
    logic [2:0] prot;
  } ac_chan_t;

  typedef struct packed {
    data_t data;
    logic  last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic     ac_ready;
    logic     cr_valid;
    crresp_t  cr_resp;
    logic     cd_valid;
    cd_chan_t cd;
  } snoop_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_CR,
    ST_CD,
    ST_UPDATE
  } snoop_state_e;

  typedef struct packed {
    crresp_t resp;
    logic    update;
    logic    invalidate;
    logic    clean;
  } snoop_decode_t;

  // A miss answers all-zero with no data and no state change.
  function automatic snoop_decode_t snoop_resp_decode(input acsnoop_t snoop,
                                                      input logic hit,
                                                      input logic dirty,
                                                      input logic shared);
    snoop_decode_t d;
    d = '0;
    if (hit) begin
      d.resp.was_unique = !shared;
      case (snoop)
        ACS_READ_ONCE: begin
          d.resp.data_transfer = 1'b1;
          d.resp.is_shared     = 1'b1;
        end
        ACS_READ_CLEAN, ACS_READ_SHARED, ACS_READ_NSD: begin
          d.resp.data_transfer = 1'b1;
          d.resp.pass_dirty    = dirty;
          d.resp.is_shared     = 1'b1;
          d.clean              = dirty;
        end
        ACS_READ_UNIQUE: begin
          d.resp.data_transfer = 1'b1;
          d.resp.pass_dirty    = dirty;
          d.invalidate         = 1'b1;
        end
        ACS_CLEAN_INVALID: begin
          d.resp.data_transfer = dirty;
          d.resp.pass_dirty    = dirty;
          d.invalidate         = 1'b1;
        end
        ACS_CLEAN_SHARED: begin
          d.resp.data_transfer = dirty;
          d.resp.pass_dirty    = dirty;
          d.resp.is_shared     = 1'b1;
          d.clean              = dirty;
        end
        ACS_MAKE_INVALID: begin
          d.invalidate = 1'b1;
        end
        default: begin
          d.resp.error = 1'b1;
        end
      endcase
    end
    d.update = d.invalidate | d.clean;
    return d;
  endfunction

endpackage

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: accepts one AC snoop at a time, looks up the cache tag,
// answers on CR, streams the line on CD when required and updates line state.
module ace_snoop_responder
  import ace_pkg::*;
#(
  parameter type         addr_t       = ace_pkg::addr_t,
  parameter type         data_t       = ace_pkg::data_t,
  parameter type         snoop_req_t  = ace_pkg::snoop_req_t,
  parameter type         snoop_resp_t = ace_pkg::snoop_resp_t,
  parameter int unsigned AXLEN        = 0,
  localparam int unsigned BeatW       = (AXLEN > 0) ? $clog2(AXLEN + 1) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  snoop_req_t       snoop_req_i,
  output snoop_resp_t      snoop_resp_o,
  output logic             lookup_valid_o,
  output addr_t            lookup_addr_o,
  input  logic             lookup_ready_i,
  input  logic             hit_i,
  input  logic             dirty_i,
  input  logic             shared_i,
  output logic             rd_valid_o,
  output logic [BeatW-1:0] rd_beat_o,
  input  logic             rd_ready_i,
  input  data_t            rd_data_i,
  output logic             upd_valid_o,
  output logic             upd_invalidate_o,
  output logic             upd_clean_o,
  input  logic             upd_ready_i,
  output snoop_state_e     state_o
);

  // Every channel transfers on the cycle where valid and ready are both high;
  // a valid, once raised, holds its payload stable until that cycle.

  snoop_state_e     state_q, state_d;
  addr_t            addr_q;
  acsnoop_t         snoop_q;
  crresp_t          cr_resp_q;
  logic             upd_req_q, upd_inv_q, upd_clean_q;
  data_t            cd_data_q;
  logic             cd_full_q;
  logic [BeatW-1:0] beat_q;
  snoop_decode_t    dec;

  logic ac_hs, lk_hs, cr_hs, rd_hs, cd_hs, up_hs, beat_last;
  logic unused_prot;

  assign unused_prot = ^snoop_req_i.ac.prot;

  assign dec = snoop_resp_decode(snoop_q, hit_i, dirty_i, shared_i);

  assign beat_last = (beat_q == BeatW'(AXLEN));
  assign ac_hs = (state_q == ST_IDLE)   && snoop_req_i.ac_valid;
  assign lk_hs = (state_q == ST_LOOKUP) && lookup_ready_i;
  assign cr_hs = (state_q == ST_CR)     && snoop_req_i.cr_ready;
  assign rd_hs = (state_q == ST_CD)     && !cd_full_q && rd_ready_i;
  assign cd_hs = (state_q == ST_CD)     && cd_full_q && snoop_req_i.cd_ready;
  assign up_hs = (state_q == ST_UPDATE) && upd_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (ac_hs) state_d = ST_LOOKUP;
      ST_LOOKUP: if (lk_hs) state_d = ST_CR;
      ST_CR: begin
        if (cr_hs) begin
          if (cr_resp_q.data_transfer) state_d = ST_CD;
          else if (upd_req_q)          state_d = ST_UPDATE;
          else                         state_d = ST_IDLE;
        end
      end
      ST_CD: begin
        if (cd_hs && beat_last) state_d = upd_req_q ? ST_UPDATE : ST_IDLE;
      end
      ST_UPDATE: if (up_hs) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Response and update flags are frozen at lookup so later hit/dirty changes
  // on the cache side cannot disturb a CR that is already being offered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q      <= '0;
      snoop_q     <= '0;
      cr_resp_q   <= '0;
      upd_req_q   <= 1'b0;
      upd_inv_q   <= 1'b0;
      upd_clean_q <= 1'b0;
      cd_data_q   <= '0;
      cd_full_q   <= 1'b0;
      beat_q      <= '0;
    end else begin
      if (ac_hs) begin
        addr_q  <= snoop_req_i.ac.addr;
        snoop_q <= snoop_req_i.ac.snoop;
      end
      if (lk_hs) begin
        cr_resp_q   <= dec.resp;
        upd_req_q   <= dec.update;
        upd_inv_q   <= dec.invalidate;
        upd_clean_q <= dec.clean;
      end
      if (rd_hs) begin
        cd_data_q <= rd_data_i;
        cd_full_q <= 1'b1;
      end
      if (cd_hs) begin
        cd_full_q <= 1'b0;
        beat_q    <= beat_last ? '0 : beat_q + BeatW'(1);
      end
    end
  end

  always_comb begin
    snoop_resp_o          = '0;
    snoop_resp_o.ac_ready = (state_q == ST_IDLE);
    snoop_resp_o.cr_valid = (state_q == ST_CR);
    snoop_resp_o.cr_resp  = cr_resp_q;
    snoop_resp_o.cd_valid = (state_q == ST_CD) && cd_full_q;
    snoop_resp_o.cd.data  = cd_data_q;
    snoop_resp_o.cd.last  = cd_full_q && beat_last;
  end

  assign lookup_valid_o   = (state_q == ST_LOOKUP);
  assign lookup_addr_o    = addr_q;
  assign rd_valid_o       = (state_q == ST_CD) && !cd_full_q;
  assign rd_beat_o        = beat_q;
  assign upd_valid_o      = (state_q == ST_UPDATE);
  assign upd_invalidate_o = upd_inv_q;
  assign upd_clean_o      = upd_clean_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed bench for ace_snoop_responder: response-table vectors with stalls,
// a mid-transfer reset, and a single-beat (AXLEN=0) instance.
module tb_ace_snoop_responder;
  import ace_pkg::*;

  localparam int unsigned AXLEN = 3;
  localparam int          NVEC  = 13;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- DUT (AXLEN=3) ----------------
  snoop_req_t   req;
  snoop_resp_t  resp;
  logic         lookup_valid, lookup_ready, hit, dirty, shared;
  addr_t        lookup_addr;
  logic         rd_valid, rd_ready;
  logic [1:0]   rd_beat;
  data_t        rd_data;
  logic         upd_valid, upd_inv, upd_clean, upd_ready;
  snoop_state_e state;

  ace_snoop_responder #(.AXLEN(AXLEN)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .snoop_req_i(req), .snoop_resp_o(resp),
    .lookup_valid_o(lookup_valid), .lookup_addr_o(lookup_addr), .lookup_ready_i(lookup_ready),
    .hit_i(hit), .dirty_i(dirty), .shared_i(shared),
    .rd_valid_o(rd_valid), .rd_beat_o(rd_beat), .rd_ready_i(rd_ready), .rd_data_i(rd_data),
    .upd_valid_o(upd_valid), .upd_invalidate_o(upd_inv), .upd_clean_o(upd_clean),
    .upd_ready_i(upd_ready), .state_o(state)
  );

  // ---------------- DUT (AXLEN=0), cache side always ready ----------------
  snoop_req_t   req0;
  snoop_resp_t  resp0;
  logic         lookup_valid0, rd_valid0, upd_valid0, upd_inv0, upd_clean0;
  addr_t        lookup_addr0;
  logic [0:0]   rd_beat0;
  snoop_state_e state0;

  ace_snoop_responder #(.AXLEN(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .snoop_req_i(req0), .snoop_resp_o(resp0),
    .lookup_valid_o(lookup_valid0), .lookup_addr_o(lookup_addr0), .lookup_ready_i(1'b1),
    .hit_i(1'b1), .dirty_i(1'b0), .shared_i(1'b0),
    .rd_valid_o(rd_valid0), .rd_beat_o(rd_beat0), .rd_ready_i(1'b1), .rd_data_i(64'h1234_5678_9ABC_DEF0),
    .upd_valid_o(upd_valid0), .upd_invalidate_o(upd_inv0), .upd_clean_o(upd_clean0),
    .upd_ready_i(1'b1), .state_o(state0)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    acsnoop_t snoop;
    logic     hit;
    logic     dirty;
    logic     shared;
    crresp_t  exp_resp;  // {WU, IS, PD, ERR, DT}
    logic     exp_cd;
    logic     exp_upd;
    logic     exp_inv;
    logic     exp_clean;
    int       stall;
  } vec_t;

  vec_t vecs[NVEC];

  function automatic data_t beat_data(input int idx, input int b);
    return {32'hCAFE_0000 + 32'(idx), 32'h0000_00B0 + 32'(b)};
  endfunction

  function automatic addr_t vec_addr(input int idx);
    return 32'h1000_0040 + 32'(idx) * 32'd64;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_beat(input int idx, input int b, input int stall);
    string t;
    t = $sformatf("v%0d_b%0d", idx, b);
    chk({t, "_rd_valid"}, 64'(rd_valid), 64'd1);
    chk({t, "_rd_beat"}, 64'(rd_beat), 64'(b));
    chk({t, "_cd_valid_pre"}, 64'(resp.cd_valid), 64'd0);
    rd_ready = 1'b1;
    rd_data  = beat_data(idx, b);
    @(negedge clk);
    rd_ready = 1'b0;
    rd_data  = data_t'({$urandom, $urandom});
    chk({t, "_cd_valid"}, 64'(resp.cd_valid), 64'd1);
    chk({t, "_cd_data"}, resp.cd.data, beat_data(idx, b));
    chk({t, "_cd_last"}, 64'(resp.cd.last), 64'(b == AXLEN));
    if (b == 1) begin
      repeat (stall) begin
        @(negedge clk);
        chk({t, "_stall_cd_valid"}, 64'(resp.cd_valid), 64'd1);
        chk({t, "_stall_cd_data"}, resp.cd.data, beat_data(idx, b));
        chk({t, "_stall_cd_last"}, 64'(resp.cd.last), 64'd0);
        chk({t, "_stall_rd_valid"}, 64'(rd_valid), 64'd0);
      end
    end
    req.cd_ready = 1'b1;
    @(negedge clk);
    req.cd_ready = 1'b0;
  endtask

  task automatic run_snoop(input int idx);
    vec_t  v;
    addr_t a;
    string t;
    v = vecs[idx];
    a = vec_addr(idx);
    t = $sformatf("v%0d", idx);
    req.ac_valid   = 1'b1;
    req.ac.addr    = a;
    req.ac.snoop   = v.snoop;
    req.ac.prot    = 3'($urandom);
    chk({t, "_ac_ready"}, 64'(resp.ac_ready), 64'd1);
    @(negedge clk);
    req.ac_valid = 1'b0;
    req.ac.snoop = 4'($urandom);
    chk({t, "_lookup_valid"}, 64'(lookup_valid), 64'd1);
    chk({t, "_lookup_addr"}, 64'(lookup_addr), 64'(a));
    chk({t, "_ac_ready_busy"}, 64'(resp.ac_ready), 64'd0);
    repeat (v.stall) begin
      @(negedge clk);
      chk({t, "_lookup_stall"}, 64'(lookup_valid), 64'd1);
      chk({t, "_cr_valid_early"}, 64'(resp.cr_valid), 64'd0);
    end
    lookup_ready = 1'b1;
    hit = v.hit; dirty = v.dirty; shared = v.shared;
    @(negedge clk);
    lookup_ready = 1'b0;
    hit = ~v.hit; dirty = ~v.dirty; shared = ~v.shared;
    chk({t, "_cr_valid"}, 64'(resp.cr_valid), 64'd1);
    chk({t, "_cr_resp"}, 64'(resp.cr_resp), 64'(v.exp_resp));
    repeat (v.stall) begin
      @(negedge clk);
      chk({t, "_cr_stall_valid"}, 64'(resp.cr_valid), 64'd1);
      chk({t, "_cr_stall_resp"}, 64'(resp.cr_resp), 64'(v.exp_resp));
    end
    req.cr_ready = 1'b1;
    @(negedge clk);
    req.cr_ready = 1'b0;
    if (v.exp_cd) begin
      for (int b = 0; b <= int'(AXLEN); b++) do_beat(idx, b, v.stall);
    end
    if (v.exp_upd) begin
      chk({t, "_upd_valid"}, 64'(upd_valid), 64'd1);
      chk({t, "_upd_inv"}, 64'(upd_inv), 64'(v.exp_inv));
      chk({t, "_upd_clean"}, 64'(upd_clean), 64'(v.exp_clean));
      repeat (v.stall) begin
        @(negedge clk);
        chk({t, "_upd_stall"}, 64'(upd_valid), 64'd1);
      end
      upd_ready = 1'b1;
      @(negedge clk);
      upd_ready = 1'b0;
    end
    chk({t, "_end_ac_ready"}, 64'(resp.ac_ready), 64'd1);
    chk({t, "_end_cr_valid"}, 64'(resp.cr_valid), 64'd0);
    chk({t, "_end_cd_valid"}, 64'(resp.cd_valid), 64'd0);
    chk({t, "_end_upd_valid"}, 64'(upd_valid), 64'd0);
    chk({t, "_end_rd_valid"}, 64'(rd_valid), 64'd0);
    chk({t, "_end_state"}, 64'(state), 64'(ST_IDLE));
  endtask

  // ---------------- test ----------------
  initial begin
    //          snoop              hit   dirty shared resp                   cd    upd   inv   clean stall
    vecs[0]  = '{ACS_READ_ONCE,     1'b1, 1'b0, 1'b0, crresp_t'(5'b11001), 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[1]  = '{ACS_READ_SHARED,   1'b1, 1'b1, 1'b1, crresp_t'(5'b01101), 1'b1, 1'b1, 1'b0, 1'b1, 2};
    vecs[2]  = '{ACS_READ_CLEAN,    1'b1, 1'b0, 1'b0, crresp_t'(5'b11001), 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[3]  = '{ACS_READ_NSD,      1'b1, 1'b1, 1'b0, crresp_t'(5'b11101), 1'b1, 1'b1, 1'b0, 1'b1, 0};
    vecs[4]  = '{ACS_READ_UNIQUE,   1'b1, 1'b1, 1'b1, crresp_t'(5'b00101), 1'b1, 1'b1, 1'b1, 1'b0, 1};
    vecs[5]  = '{ACS_READ_UNIQUE,   1'b0, 1'b0, 1'b0, crresp_t'(5'b00000), 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[6]  = '{ACS_CLEAN_INVALID, 1'b1, 1'b1, 1'b0, crresp_t'(5'b10101), 1'b1, 1'b1, 1'b1, 1'b0, 5};
    vecs[7]  = '{ACS_CLEAN_INVALID, 1'b1, 1'b0, 1'b1, crresp_t'(5'b00000), 1'b0, 1'b1, 1'b1, 1'b0, 0};
    vecs[8]  = '{ACS_CLEAN_SHARED,  1'b1, 1'b1, 1'b1, crresp_t'(5'b01101), 1'b1, 1'b1, 1'b0, 1'b1, 0};
    vecs[9]  = '{ACS_CLEAN_SHARED,  1'b1, 1'b0, 1'b0, crresp_t'(5'b11000), 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[10] = '{ACS_MAKE_INVALID,  1'b1, 1'b0, 1'b0, crresp_t'(5'b10000), 1'b0, 1'b1, 1'b1, 1'b0, 0};
    vecs[11] = '{4'b1111,           1'b1, 1'b1, 1'b0, crresp_t'(5'b10010), 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[12] = '{ACS_READ_SHARED,   1'b0, 1'b1, 1'b0, crresp_t'(5'b00000), 1'b0, 1'b0, 1'b0, 1'b0, 0};

    req = '0; req0 = '0;
    lookup_ready = 1'b0; hit = 1'b0; dirty = 1'b0; shared = 1'b0;
    rd_ready = 1'b0; rd_data = '0; upd_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ac_ready", 64'(resp.ac_ready), 64'd1);
    chk("rst_cr_valid", 64'(resp.cr_valid), 64'd0);
    chk("rst_cr_resp", 64'(resp.cr_resp), 64'd0);
    chk("rst_cd_valid", 64'(resp.cd_valid), 64'd0);
    chk("rst_cd_data", resp.cd.data, 64'd0);
    chk("rst_lookup_valid", 64'(lookup_valid), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_beat", 64'(rd_beat), 64'd0);
    chk("rst_upd_valid", 64'(upd_valid), 64'd0);
    chk("rst_state", 64'(state), 64'(ST_IDLE));

    for (int i = 0; i < NVEC; i++) run_snoop(i);

    // Reset while beat 2 of a ReadShared is being offered on CD.
    req.ac_valid = 1'b1; req.ac.addr = vec_addr(20); req.ac.snoop = ACS_READ_SHARED;
    @(negedge clk);
    req.ac_valid = 1'b0;
    lookup_ready = 1'b1; hit = 1'b1; dirty = 1'b1; shared = 1'b1;
    @(negedge clk);
    lookup_ready = 1'b0;
    chk("rmid_cr_resp", 64'(resp.cr_resp), 64'h0D);
    req.cr_ready = 1'b1;
    @(negedge clk);
    req.cr_ready = 1'b0;
    do_beat(20, 0, 0);
    do_beat(20, 1, 0);
    rd_ready = 1'b1; rd_data = beat_data(20, 2);
    @(negedge clk);
    rd_ready = 1'b0;
    chk("rmid_cd_valid_b2", 64'(resp.cd_valid), 64'd1);
    rst_n = 1'b0;
    #2;
    chk("rmid_in_rst_cd_valid", 64'(resp.cd_valid), 64'd0);
    chk("rmid_in_rst_ac_ready", 64'(resp.ac_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    req.cr_ready = 1'b1; req.cd_ready = 1'b1;
    lookup_ready = 1'b1; rd_ready = 1'b1; upd_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rmid_post%0d_cd_valid", c), 64'(resp.cd_valid), 64'd0);
      chk($sformatf("rmid_post%0d_cr_valid", c), 64'(resp.cr_valid), 64'd0);
      chk($sformatf("rmid_post%0d_upd_valid", c), 64'(upd_valid), 64'd0);
      chk($sformatf("rmid_post%0d_ac_ready", c), 64'(resp.ac_ready), 64'd1);
    end
    chk("rmid_post_rd_beat", 64'(rd_beat), 64'd0);
    req.cr_ready = 1'b0; req.cd_ready = 1'b0;
    lookup_ready = 1'b0; rd_ready = 1'b0; upd_ready = 1'b0;

    // Run one more snoop after the abandoned one to show the beat counter restarted.
    run_snoop(0);

    // Single-beat line: ReadOnce hit clean unique on the AXLEN=0 instance.
    req0.ac_valid = 1'b1; req0.ac.addr = 32'h0000_2000; req0.ac.snoop = ACS_READ_ONCE;
    @(negedge clk);
    req0.ac_valid = 1'b0;
    @(negedge clk);
    chk("ax0_cr_valid", 64'(resp0.cr_valid), 64'd1);
    chk("ax0_cr_resp", 64'(resp0.cr_resp), 64'h19);
    req0.cr_ready = 1'b1;
    @(negedge clk);
    req0.cr_ready = 1'b0;
    chk("ax0_rd_valid", 64'(rd_valid0), 64'd1);
    chk("ax0_rd_beat", 64'(rd_beat0), 64'd0);
    @(negedge clk);
    chk("ax0_cd_valid", 64'(resp0.cd_valid), 64'd1);
    chk("ax0_cd_last", 64'(resp0.cd.last), 64'd1);
    chk("ax0_cd_data", resp0.cd.data, 64'h1234_5678_9ABC_DEF0);
    req0.cd_ready = 1'b1;
    @(negedge clk);
    req0.cd_ready = 1'b0;
    chk("ax0_end_ac_ready", 64'(resp0.ac_ready), 64'd1);
    chk("ax0_end_cd_valid", 64'(resp0.cd_valid), 64'd0);
    chk("ax0_end_upd_valid", 64'(upd_valid0), 64'd0);
    chk("ax0_end_state", 64'(state0), 64'(ST_IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
